imem_loader: RTL and testbench

- Upstream instruction source for the single-cycle RV32 core.
- Accepts the program as a little-endian byte stream over a valid/ready handshake and packs it into 32-bit words in an internal instruction memory.
- Then releases the core and serves its PC-addressed fetches combinationally.
- Tracks core exit and parks in a halted state until reset.

---
 rtl/imem_loader_if.sv | 11 +
 rtl/imem_loader.sv | 120 ++++++++++++
 tb/tb_imem_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream load port of the instruction memory loader: one program byte
// per transfer, with in_last marking the final byte of the program.
interface imem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader for the single-cycle RV32 core.
// Packs a little-endian byte stream into 32-bit words, then releases the core
// and serves its PC-addressed fetches combinationally until the core exits.
module imem_loader #(
  parameter int INS = 5,
  parameter int CW  = $clog2(INS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus,
  input  logic [31:0]   pc,
  output logic [31:0]   instr,
  output logic          core_run,
  output logic          halted,
  input  logic          core_exit,
  output logic [CW-1:0] word_count,
  output logic          err_align,
  output logic          fetch_fault
);

  typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_q;
  logic [31:0] mem [INS];

  logic        accept;
  logic        word_end;
  logic        last_byte;
  logic [31:0] wdata;
  logic        fetch_ok;

  // A word closes on lane 3 or on an early in_last; the load ends on in_last
  // or when the final lane of the last memory word arrives.
  assign accept    = bus.in_valid && (state_q == LOAD);
  assign word_end  = bus.in_last || (byte_cnt == 2'd3);
  assign last_byte = accept && (bus.in_last ||
                     ((byte_cnt == 2'd3) && (word_count == CW'(INS - 1))));

  // Fetches are valid only when word aligned and inside the loaded words.
  assign fetch_ok = (pc[1:0] == 2'b00) &&
                    (pc[31:2] < {{(30 - CW){1'b0}}, word_count});
  assign instr    = fetch_ok ? mem[pc[CW+1:2]] : 32'h0;

  // Assemble the word being written: lower lanes come from the assembly
  // register, the current byte lands in its lane, upper lanes are zero.
  always_comb begin
    wdata = 32'h0;
    case (byte_cnt)
      2'd0: wdata = {24'h0, bus.in_data};
      2'd1: wdata = {16'h0, bus.in_data, asm_q[7:0]};
      2'd2: wdata = {8'h0, bus.in_data, asm_q[15:0]};
      default: wdata = {bus.in_data, asm_q[23:0]};
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    core_run     = 1'b0;
    halted       = 1'b0;
    case (state_q)
      LOAD: begin
        bus.in_ready = 1'b1;
        if (last_byte) state_d = RUN;
      end
      RUN: begin
        core_run = 1'b1;
        if (core_exit) state_d = HALT;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = LOAD;
    endcase
  end

  // Byte lane tracking, word counting and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt    <= 2'd0;
      asm_q       <= 24'h0;
      word_count  <= '0;
      err_align   <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      if (accept) begin
        if (word_end) begin
          byte_cnt   <= 2'd0;
          asm_q      <= 24'h0;
          word_count <= word_count + CW'(1);
          if (byte_cnt != 2'd3) err_align <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
          case (byte_cnt)
            2'd0:    asm_q[7:0]   <= bus.in_data;
            2'd1:    asm_q[15:8]  <= bus.in_data;
            default: asm_q[23:16] <= bus.in_data;
          endcase
        end
      end
      if (core_run && !fetch_ok) fetch_fault <= 1'b1;
    end
  end

  // Instruction memory write; contents survive reset, word_count gates reads.
  always_ff @(posedge clk) begin
    if (!rst && accept && word_end) mem[word_count] <= wdata;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader with hand-computed expectations.
module tb_imem_loader;

  localparam int INS = 5;
  localparam int CW  = $clog2(INS + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   pc = 32'h0;
  logic [31:0]   instr;
  logic          core_run;
  logic          halted;
  logic          core_exit = 1'b0;
  logic [CW-1:0] word_count;
  logic          err_align;
  logic          fetch_fault;

  int total = 0;
  int bad   = 0;

  logic [7:0] basic [8] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

  imem_loader_if bus ();

  imem_loader #(.INS(INS)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .pc          (pc),
    .instr       (instr),
    .core_run    (core_run),
    .halted      (halted),
    .core_exit   (core_exit),
    .word_count  (word_count),
    .err_align   (err_align),
    .fetch_fault (fetch_fault)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Safety bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] run did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    core_exit = 1'b0;
    pc = 32'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic apply_byte(input logic [7:0] b, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_last  = l;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic apply_basic();
    for (int i = 0; i < 8; i++) apply_byte(basic[i], i == 7);
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    #1;
    check_output(tag, instr, exp);
  endtask

  initial begin
    bus.in_data  = 8'h0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    // Reset state
    apply_reset();
    check_output("rst_ready", {31'h0, bus.in_ready}, 32'h1);
    check_output("rst_run", {31'h0, core_run}, 32'h0);
    check_output("rst_halted", {31'h0, halted}, 32'h0);
    check_output("rst_wc", 32'(word_count), 32'h0);
    check_output("rst_align", {31'h0, err_align}, 32'h0);
    check_output("rst_fault", {31'h0, fetch_fault}, 32'h0);

    // Basic load
    apply_basic();
    check_output("basic_wc", 32'(word_count), 32'h2);
    check_output("basic_run", {31'h0, core_run}, 32'h1);
    check_output("basic_ready", {31'h0, bus.in_ready}, 32'h0);
    check_output("basic_align", {31'h0, err_align}, 32'h0);
    check_fetch("basic_pc0", 32'h0, 32'h00500013);
    check_fetch("basic_pc4", 32'h4, 32'h00100093);
    check_output("basic_fault_pre", {31'h0, fetch_fault}, 32'h0);
    check_fetch("basic_pc8", 32'h8, 32'h0);
    tick();
    check_output("basic_fault", {31'h0, fetch_fault}, 32'h1);

    // Full load: 20 bytes 00..13, no in_last
    apply_reset();
    for (int i = 0; i < 19; i++) apply_byte(8'(i), 1'b0);
    check_output("full_run_early", {31'h0, core_run}, 32'h0);
    check_output("full_wc_early", 32'(word_count), 32'h4);
    apply_byte(8'h13, 1'b0);
    check_output("full_run", {31'h0, core_run}, 32'h1);
    check_output("full_ready", {31'h0, bus.in_ready}, 32'h0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h14;
    tick();
    tick();
    bus.in_valid = 1'b0;
    check_output("full_wc", 32'(word_count), 32'h5);
    check_fetch("full_pc0", 32'h0, 32'h03020100);
    check_fetch("full_pc16", 32'h10, 32'h13121110);
    check_fetch("full_pc20", 32'h14, 32'h0);
    pc = 32'h0;
    check_output("full_fault", {31'h0, fetch_fault}, 32'h0);

    // Partial word
    apply_reset();
    apply_byte(8'hAA, 1'b0);
    apply_byte(8'hBB, 1'b0);
    apply_byte(8'hCC, 1'b1);
    check_output("part_wc", 32'(word_count), 32'h1);
    check_output("part_align", {31'h0, err_align}, 32'h1);
    check_output("part_run", {31'h0, core_run}, 32'h1);
    check_fetch("part_pc0", 32'h0, 32'h00CCBBAA);
    check_fetch("part_pc4", 32'h4, 32'h0);
    pc = 32'h0;

    // Valid gaps with a stray in_last while in_valid is low
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      apply_byte(basic[i], i == 7);
      if (i < 7) begin
        for (int g = 0; g < 3; g++) begin
          bus.in_last = (i == 3) && (g == 1);
          tick();
        end
        bus.in_last = 1'b0;
      end
      if (i == 6) check_output("gap_run_early", {31'h0, core_run}, 32'h0);
    end
    check_output("gap_wc", 32'(word_count), 32'h2);
    check_output("gap_align", {31'h0, err_align}, 32'h0);
    check_fetch("gap_pc0", 32'h0, 32'h00500013);
    check_fetch("gap_pc4", 32'h4, 32'h00100093);

    // Misaligned fetch, then exit
    check_fetch("mis_pc2", 32'h2, 32'h0);
    tick();
    check_output("mis_fault", {31'h0, fetch_fault}, 32'h1);
    pc = 32'h0;
    core_exit = 1'b1;
    tick();
    core_exit = 1'b0;
    check_output("exit_halted", {31'h0, halted}, 32'h1);
    check_output("exit_run", {31'h0, core_run}, 32'h0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    bus.in_last  = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_output("halt_hold", {31'h0, halted}, 32'h1);
    check_output("halt_run", {31'h0, core_run}, 32'h0);
    check_output("halt_ready", {31'h0, bus.in_ready}, 32'h0);
    check_output("halt_wc", 32'(word_count), 32'h2);
    check_fetch("halt_pc0", 32'h0, 32'h00500013);

    // Reset mid-load, core_exit ignored in LOAD
    apply_reset();
    core_exit = 1'b1;
    tick();
    core_exit = 1'b0;
    check_output("load_exit_halted", {31'h0, halted}, 32'h0);
    check_output("load_exit_ready", {31'h0, bus.in_ready}, 32'h1);
    for (int i = 1; i <= 6; i++) apply_byte(8'(i), 1'b0);
    check_output("mid_wc", 32'(word_count), 32'h1);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    bus.in_last  = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_output("mid_rst_wc", 32'(word_count), 32'h0);
    check_output("mid_rst_align", {31'h0, err_align}, 32'h0);
    check_output("mid_rst_run", {31'h0, core_run}, 32'h0);
    apply_basic();
    check_output("mid_wc_final", 32'(word_count), 32'h2);
    check_output("mid_align_final", {31'h0, err_align}, 32'h0);
    check_fetch("mid_pc0", 32'h0, 32'h00500013);
    check_fetch("mid_pc4", 32'h4, 32'h00100093);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
